// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one 2-byte UART transmitter between N_REQ requesters.
// Define UART_TXS_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int IDW          = 2,
  parameter int FRAME_CYCLES = 25,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                 clk_9k6hz,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  data_in,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_en,
  output logic [15:0]          tx_data,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);
  localparam logic [2:0] FLUSH = 3'd0, IDLE = 3'd1, KICK = 3'd2, BUSY = 3'd3, GAP = 3'd4;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d, grant_q, grant_d, win;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [15:0]      tx_data_q, tx_data_d;
  logic             tx_en_q, tx_en_d, busy_q, busy_d, done_q, done_d;
  // Scan downward so the last hit is the highest-priority candidate.
  always_comb begin
    win = '0;
`ifdef UART_TXS_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[IDW'(i)]) win = IDW'(i);
`else
    for (int k = N_REQ; k >= 1; k--)
      if (req[IDW'((int'(ptr_q) + k) % N_REQ)]) win = IDW'((int'(ptr_q) + k) % N_REQ);
`endif
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    ack_d     = ack_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      FLUSH: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else cnt_d = cnt_q - 1'b1;
      end
      IDLE: if (|req) begin
        tx_data_d = data_in[16*win +: 16];
        ack_d     = N_REQ'(1) << win;
        grant_d   = win;
        ptr_d     = win;
        busy_d    = 1'b1;
        state_d   = KICK;
      end
      KICK: begin
        ack_d   = '0;
        tx_en_d = 1'b1;
        cnt_d   = CW'(FRAME_CYCLES - 1);
        state_d = BUSY;
      end
      BUSY: begin
        tx_en_d = 1'b0;
        cnt_d   = cnt_q - 1'b1;
        done_d  = cnt_q == CW'(1);
        if (cnt_q == '0) begin
          done_d  = 1'b0;
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = FLUSH;
    endcase
  end
  // The transmitter has no reset, so reset always drains a possible in-flight frame.
  always_ff @(posedge clk_9k6hz) begin
    if (rst) begin
      state_q   <= FLUSH;
      cnt_q     <= CW'(FRAME_CYCLES + GAP_CYCLES - 1);
      ptr_q     <= IDW'(N_REQ - 1);
      grant_q   <= IDW'(N_REQ - 1);
      ack_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 16'h0000;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign ack      = ack_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed self-checking bench for uart_tx_scheduler.
module tb_uart_tx_scheduler;
  logic        clk_9k6hz = 0;
  logic        rst = 1;
  logic [3:0]  req = '0;
  logic [63:0] data_in = '0;
  logic [3:0]  ack;
  logic        tx_en, busy, done;
  logic [15:0] tx_data;
  logic [1:0]  grant_id;
  int tests = 0, fails = 0;

  uart_tx_scheduler dut (
    .clk_9k6hz(clk_9k6hz), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .tx_en(tx_en), .tx_data(tx_data), .grant_id(grant_id), .busy(busy), .done(done)
  );

  always #5 clk_9k6hz = ~clk_9k6hz;

  task automatic tick;
    @(posedge clk_9k6hz);
    @(negedge clk_9k6hz);
  endtask

  task automatic wait_ack(input int max, output int n);
    n = 0;
    while (ack == 4'b0 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    req = '0;
    tick();
    tick();
    tests++;
    if ({ack, tx_en, tx_data, grant_id, busy, done} !== {4'b0, 1'b0, 16'h0000, 2'd3, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset: ack=%b tx_en=%b tx_data=%h grant=%0d busy=%b done=%b, want 0 0 0000 3 1 0",
               ack, tx_en, tx_data, grant_id, busy, done);
    end
  endtask

  task automatic test_flush_first_frame;
    int bad = 0, pulses = 0, done_at = -1, data_bad = 0;
    data_in[15:0] = 16'hA53C;
    rst = 0;
    req = 4'b0001;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (busy !== 1'b1 || ack !== 4'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL flush_hold: %0d cycles with busy low or ack, want 0", bad);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || ack !== 4'b0) begin
      fails++;
      $display("FAIL flush_end: busy=%b ack=%b, want 0 0000", busy, ack);
    end
    tick();
    tests++;
    if (ack !== 4'b0001 || grant_id !== 2'd0 || tx_data !== 16'hA53C || busy !== 1'b1) begin
      fails++;
      $display("FAIL first_ack: ack=%b grant=%0d tx_data=%h busy=%b, want 0001 0 a53c 1", ack, grant_id, tx_data, busy);
    end
    req = '0;
    tick();
    tests++;
    if (tx_en !== 1'b1 || ack !== 4'b0) begin
      fails++;
      $display("FAIL kick: tx_en=%b ack=%b, want 1 0000", tx_en, ack);
    end
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (tx_en === 1'b1) pulses++;
      if (tx_data !== 16'hA53C) data_bad++;
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    tests++;
    if (pulses != 0 || data_bad != 0 || done_at != 24) begin
      fails++;
      $display("FAIL frame: extra tx_en=%0d data changes=%0d done_at=%0d, want 0 0 24", pulses, data_bad, done_at);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL gap: done=%b busy=%b, want 0 1", done, busy);
    end
    tick();
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL back_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_round_robin;
    int n;
    int exp_id;
    rst = 1;
    tick();
    data_in = 64'h4444_3333_2222_1111;
    rst = 0;
    req = 4'b1111;
    wait_ack(40, n);
    tests++;
    if (ack !== 4'b0001 || n != 28) begin
      fails++;
      $display("FAIL rr_first: ack=%b after %0d cycles, want 0001 after 28", ack, n);
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      wait_ack(40, n);
`ifdef UART_TXS_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = j % 4;
`endif
      tests++;
      if (ack !== (4'b0001 << exp_id) || grant_id !== 2'(exp_id) || n + 1 != 29
          || tx_data !== 16'(16'h1111 * (exp_id + 1))) begin
        fails++;
        $display("FAIL rr_%0d: ack=%b grant=%0d tx_data=%h spacing=%0d, want id %0d spacing 29",
                 j, ack, grant_id, tx_data, n + 1, exp_id);
      end
    end
    req = '0;
    wait_idle(40);
  endtask

  task automatic test_late_req;
    int n;
    req = 4'b0001;
    wait_ack(5, n);
    tests++;
    if (ack !== 4'b0001) begin
      fails++;
      $display("FAIL late_first: ack=%b, want 0001", ack);
    end
    req = '0;
    repeat (5) tick();
    req = 4'b0010;
    repeat (5) tick();
    req = 4'b0110;
    wait_ack(40, n);
    tests++;
    if (ack !== 4'b0010 || grant_id !== 2'd1) begin
      fails++;
      $display("FAIL late_req1: ack=%b grant=%0d, want 0010 1", ack, grant_id);
    end
    req = 4'b0100;
    tick();
    wait_ack(40, n);
    tests++;
    if (ack !== 4'b0100 || grant_id !== 2'd2 || n + 1 != 29) begin
      fails++;
      $display("FAIL late_req2: ack=%b grant=%0d spacing=%0d, want 0100 2 29", ack, grant_id, n + 1);
    end
    req = '0;
    wait_idle(40);
  endtask

  task automatic test_reset_mid;
    int n, bad = 0;
    req = 4'b0001;
    wait_ack(5, n);
    tick();
    repeat (10) tick();
    rst = 1;
    tick();
    tests++;
    if (tx_en !== 1'b0 || busy !== 1'b1 || ack !== 4'b0 || tx_data !== 16'h0000) begin
      fails++;
      $display("FAIL mid_reset: tx_en=%b busy=%b ack=%b tx_data=%h, want 0 1 0000 0000", tx_en, busy, ack, tx_data);
    end
    rst = 0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (busy !== 1'b1 || ack !== 4'b0 || tx_en !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mid_flush: %0d bad cycles, want 0", bad);
    end
    tick();
    tick();
    tests++;
    if (ack !== 4'b0001) begin
      fails++;
      $display("FAIL mid_regrant: ack=%b, want 0001", ack);
    end
    req = '0;
    wait_idle(40);
  endtask

  task automatic test_pulse_drop;
    int n, bad = 0;
    req = 4'b0001;
    wait_ack(5, n);
    req = '0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL pulse_done: done=%b after %0d cycles, want 1", done, n);
    end
    tick();
    req = 4'b1000;
    tick();
    req = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ack !== 4'b0) bad++;
    end
    tests++;
    if (bad != 0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      fails++;
      $display("FAIL pulse_drop: ack cycles=%0d busy=%b grant=%0d, want 0 0 0", bad, busy, grant_id);
    end
  endtask

  initial begin
    @(negedge clk_9k6hz);
    test_reset();
    test_flush_first_frame();
    test_round_robin();
    test_late_req();
    test_reset_mid();
    test_pulse_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
